// File: rtl/div_writeback_seq.sv
// rtl/div_writeback_seq.sv - divide result writeback: quotient/remainder beats plus flag update
module div_writeback_seq #(
    parameter int WIDTH = 4,
    parameter int ADDR  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_quot,
    input  logic [WIDTH-1:0] in_mod,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic [ADDR-1:0]  in_rd,
    input  logic             in_want_mod,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [ADDR-1:0]  wb_addr,
    output logic [WIDTH-1:0] wb_data,
    output logic             flags_we,
    output logic [3:0]       flags
);

    typedef enum logic [1:0] {IDLE, WB_QUOT, WB_MOD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [ADDR-1:0]  rd_q, rd_d;
    logic             want_mod_q, want_mod_d;
    logic             dz_q, dz_d;
    logic             flags_we_q, flags_we_d;
    logic [3:0]       flags_q, flags_d;
    logic [WIDTH-1:0] eff_quot, eff_mod;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            quot_q     <= '0;
            mod_q      <= '0;
            dividend_q <= '0;
            rd_q       <= '0;
            want_mod_q <= 1'b0;
            dz_q       <= 1'b0;
            flags_we_q <= 1'b0;
            flags_q    <= 4'b0000;
        end else begin
            state_q    <= state_d;
            quot_q     <= quot_d;
            mod_q      <= mod_d;
            dividend_q <= dividend_d;
            rd_q       <= rd_d;
            want_mod_q <= want_mod_d;
            dz_q       <= dz_d;
            flags_we_q <= flags_we_d;
            flags_q    <= flags_d;
        end
    end

    // Divide-by-zero convention: all-ones quotient, dividend as remainder.
    always_comb begin
        eff_quot = dz_q ? '1 : quot_q;
        eff_mod  = dz_q ? dividend_q : mod_q;
    end

    always_comb begin
        state_d    = state_q;
        quot_d     = quot_q;
        mod_d      = mod_q;
        dividend_d = dividend_q;
        rd_d       = rd_q;
        want_mod_d = want_mod_q;
        dz_d       = dz_q;
        flags_we_d = 1'b0;
        flags_d    = flags_q;
        in_ready   = 1'b0;
        wb_valid   = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;

        case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    quot_d     = in_quot;
                    mod_d      = in_mod;
                    dividend_d = in_dividend;
                    rd_d       = in_rd;
                    want_mod_d = in_want_mod;
                    dz_d       = (in_divisor == '0);
                    state_d    = WB_QUOT;
                end
            end
            WB_QUOT: begin
                wb_valid = 1'b1;
                wb_addr  = rd_q;
                wb_data  = eff_quot;
                if (wb_ready) begin
                    flags_we_d = 1'b1;
                    flags_d    = {eff_quot[WIDTH-1], (eff_quot == '0), 1'b0, dz_q};
                    state_d    = want_mod_q ? WB_MOD : IDLE;
                end
            end
            WB_MOD: begin
                wb_valid = 1'b1;
                wb_addr  = rd_q + {{(ADDR-1){1'b0}}, 1'b1};
                wb_data  = eff_mod;
                if (wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        flags_we = flags_we_q;
        flags    = flags_q;
    end

endmodule

// File: tb/tb_div_writeback_seq.sv
// tb/tb_div_writeback_seq.sv - randomized and directed bench for div_writeback_seq
module tb_div_writeback_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_quot, in_mod, in_dividend, in_divisor, in_rd;
    logic       in_want_mod;
    logic       wb_valid;
    logic       wb_ready;
    logic [3:0] wb_addr, wb_data;
    logic       flags_we;
    logic [3:0] flags;

    int checks = 0;
    int errors = 0;

    div_writeback_seq #(.WIDTH(4), .ADDR(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_quot(in_quot), .in_mod(in_mod),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .in_rd(in_rd), .in_want_mod(in_want_mod),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data),
        .flags_we(flags_we), .flags(flags)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [3:0] a, input logic [3:0] b,
                                  output logic [3:0] q, output logic [3:0] r,
                                  output logic [3:0] fl);
        if (b == 0) begin
            q = 4'hF;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
        fl = {q[3], (q == 0), 1'b0, (b == 0)};
    endfunction

    task automatic randomize_inputs();
        in_quot     = 4'($urandom);
        in_mod      = 4'($urandom);
        in_dividend = 4'($urandom);
        in_divisor  = 4'($urandom);
        in_rd       = 4'($urandom);
        in_want_mod = 1'($urandom);
    endtask

    // One full transaction starting in IDLE at a negedge; stall = wb_ready-low cycles per beat.
    task automatic run_txn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] rd,
                           input bit wm, input int stall, input bit noise);
        logic [3:0] q, r, fl;
        logic [3:0] exp_addr [2];
        logic [3:0] exp_data [2];
        int nb;
        model(a, b, q, r, fl);
        exp_addr[0] = rd;
        exp_data[0] = q;
        exp_addr[1] = rd + 4'd1;
        exp_data[1] = r;
        nb = wm ? 2 : 1;

        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: got %b expected 1", in_ready);
        end
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        in_quot     = (b == 0) ? 4'($urandom) : a / b;
        in_mod      = (b == 0) ? 4'($urandom) : a % b;
        in_rd       = rd;
        in_want_mod = wm;
        wb_ready    = 1'($urandom);
        @(negedge clk);

        for (int k = 0; k < nb; k++) begin
            for (int s = 0; s <= stall; s++) begin
                if (noise) begin
                    in_valid = 1'b1;
                    randomize_inputs();
                end else begin
                    in_valid = 1'b0;
                end
                checks++;
                if (wb_valid !== 1'b1 || wb_addr !== exp_addr[k] || wb_data !== exp_data[k]) begin
                    errors++;
                    $display("FAIL beat%0d_cyc%0d: got v=%b addr=%h data=%h expected v=1 addr=%h data=%h",
                             k, s, wb_valid, wb_addr, wb_data, exp_addr[k], exp_data[k]);
                end
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_ready: got %b expected 0", in_ready);
                end
                checks++;
                if (flags_we !== (k == 1 && s == 0)) begin
                    errors++;
                    $display("FAIL flags_we_beat%0d_cyc%0d: got %b expected %b", k, s, flags_we, (k == 1 && s == 0));
                end
                wb_ready = (s == stall);
                @(negedge clk);
            end
        end

        in_valid = 1'b0;
        wb_ready = 1'($urandom);
        checks++;
        if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL return_idle: got wb_valid=%b in_ready=%b expected 0 1", wb_valid, in_ready);
        end
        checks++;
        if (flags_we !== !wm) begin
            errors++;
            $display("FAIL flags_we_after: got %b expected %b", flags_we, !wm);
        end
        checks++;
        if (flags !== fl) begin
            errors++;
            $display("FAIL flags_value: got %b expected %b", flags, fl);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; wb_ready = 1'b0;
        randomize_inputs();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || wb_valid !== 1'b0 || wb_addr !== 4'h0 || wb_data !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b v=%b a=%h d=%h expected 0 0 0 0",
                     in_ready, wb_valid, wb_addr, wb_data);
        end
        checks++;
        if (flags_we !== 1'b0 || flags !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got we=%b flags=%b expected 0 0000", flags_we, flags);
        end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got rdy=%b v=%b expected 1 0", in_ready, wb_valid);
        end
    endtask

    task automatic test_directed();
        run_txn(4'd10, 4'd2, 4'd3,  1'b1, 0, 1'b0);
        run_txn(4'd5,  4'd2, 4'd7,  1'b0, 0, 1'b0);
        run_txn(4'd12, 4'd0, 4'd2,  1'b1, 0, 1'b0);
        run_txn(4'd0,  4'd3, 4'd15, 1'b1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_txn(4'd10, 4'd3, 4'd1, 1'b1, 3, 1'b1);
        run_txn(4'd9,  4'd0, 4'd8, 1'b0, 2, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            logic [3:0] b;
            b = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom);
            run_txn(4'($urandom), b, 4'($urandom), 1'($urandom),
                    int'($urandom_range(0, 2)), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid_op();
        // Reset while stalled in the remainder beat.
        in_valid = 1'b1; in_dividend = 4'd8; in_divisor = 4'd4; in_quot = 4'd2; in_mod = 4'd0;
        in_rd = 4'd5; in_want_mod = 1'b1; wb_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || flags !== 4'b0000 || flags_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_mod: got v=%b flags=%b we=%b expected 0 0000 0", wb_valid, flags, flags_we);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_mod_release: got rdy=%b v=%b expected 1 0", in_ready, wb_valid);
        end

        // Reset coinciding with the quotient handshake discards the flag pulse.
        in_valid = 1'b1; in_dividend = 4'd15; in_divisor = 4'd0; in_rd = 4'd9; in_want_mod = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; wb_ready = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || flags_we !== 1'b0 || flags !== 4'b0000) begin
            errors++;
            $display("FAIL rst_in_quot: got v=%b we=%b flags=%b expected 0 0 0000", wb_valid, flags_we, flags);
        end
        @(negedge clk);
        checks++;
        if (flags_we !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_quot_after: got we=%b rdy=%b expected 0 1", flags_we, in_ready);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; wb_ready = 1'b0;
        in_quot = '0; in_mod = '0; in_dividend = '0; in_divisor = '0; in_rd = '0; in_want_mod = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        run_txn(4'd7, 4'd7, 4'd0, 1'b1, 1, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
